// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine with valid/ready handshakes and status flags.
// Define SEQ_SHIFT_FAST_EN to perform up to four bit-steps per clock in SHIFT.
module seq_shift_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [3:0]         shift_op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               carry_out,
  output logic               zero_out,
  output logic               neg_out,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_LSL = 4'b0001;
  localparam logic [3:0] OP_LSR = 4'b0010;
  localparam logic [3:0] OP_ROR = 4'b0011;
  localparam logic [3:0] OP_ROL = 4'b0100;
  localparam logic [3:0] OP_ASR = 4'b0101;

`ifdef SEQ_SHIFT_FAST_EN
  localparam int STEPS_PER_CLK = 4;
`else
  localparam int STEPS_PER_CLK = 1;
`endif

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SHAMT_W-1:0]   count_q, count_d;
  logic [3:0]           op_q, op_d;
  logic                 carry_q, carry_d;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_ASR);
  endfunction

  // One 1-bit step; returns {carry, data}.
  function automatic logic [WIDTH:0] step1(input logic [3:0] op, input logic [WIDTH-1:0] d);
    logic [WIDTH:0] r;
    case (op)
      OP_LSL:  r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {d[0], 1'b0, d[WIDTH-1:1]};
      OP_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
      OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      OP_ASR:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      default: r = {1'b0, d};
    endcase
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)
                 state_d = (shamt == '0 || !is_shift_op(shift_op)) ? DONE : SHIFT;
      SHIFT:   if (count_d == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // NOTE: every combinational output is given a default before the case so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    op_d    = op_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: if (in_valid) begin
        data_d  = data_in;
        count_d = shamt;
        op_d    = shift_op;
        carry_d = 1'b0;
      end
      SHIFT: begin
        for (int i = 0; i < STEPS_PER_CLK; i++) begin
          if (count_d != '0) begin
            {carry_d, data_d} = step1(op_q, data_d);
            count_d           = count_d - SHAMT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: all datapath registers are reset so an abort mid-shift leaves the
  // outputs in a defined, all-zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      op_q    <= op_d;
      carry_q <= carry_d;
    end
  end

  assign data_out  = data_q;
  assign carry_out = carry_q;
  // Zero flag qualified by DONE so it stays low out of reset.
  assign zero_out  = (state_q == DONE) && (data_q == '0);
  assign neg_out   = data_q[WIDTH-1];

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed table, corner sequences,
// and randomized requests scored against an arithmetic reference model.
module tb_seq_shift_unit;
  localparam int W  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  data_in = '0;
  logic [3:0]    shift_op = '0;
  logic [SW-1:0] shamt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  data_out;
  logic          carry_out, zero_out, neg_out, busy;

  int n_pass = 0;
  int n_tot  = 0;

  seq_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shift_op(shift_op), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .carry_out(carry_out),
    .zero_out(zero_out), .neg_out(neg_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] d;
    int         n;
    logic [7:0] exp_d;
    logic       exp_c;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit is_shift(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd5;
  endfunction

  function automatic int lat_of(input logic [3:0] op, input int n);
    if (!is_shift(op) || n == 0) return 1;
`ifdef SEQ_SHIFT_FAST_EN
    return 1 + (n + 3) / 4;
`else
    return 1 + n;
`endif
  endfunction

  // Closed-form result of shifting d by n positions.
  task automatic model(input logic [3:0] op, input logic [7:0] d, input int n,
                       output logic [7:0] r, output logic c);
    logic [15:0] t;
    int k;
    r = d; c = 1'b0;
    if (is_shift(op) && n != 0) begin
      k = n % 8;
      case (op)
        4'd1: if (n > 8) begin r = 0; c = 0; end
              else begin t = {8'h00, d} << n; r = t[7:0]; c = t[8]; end
        4'd2: if (n > 8) begin r = 0; c = 0; end
              else begin t = {d, 8'h00} >> n; r = t[15:8]; c = t[7]; end
        4'd3: begin r = (d >> k) | (d << (8 - k)); c = r[7]; end
        4'd4: begin r = (d << k) | (d >> (8 - k)); c = r[0]; end
        default: if (n >= 8) begin r = {8{d[7]}}; c = d[7]; end
                 else begin r = 8'($signed(d) >>> n); c = d[n-1]; end
      endcase
    end
  endtask

  task automatic transact(input string name, input logic [3:0] op, input logic [7:0] d,
                          input int n, input logic [7:0] ed, input logic ec, input int hold);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; shift_op = op; data_in = d; shamt = SW'(n); out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, " done"}, out_valid, 1);
    if (!out_valid) return;
    check({name, " latency"}, lat, lat_of(op, n));
    check({name, " data"}, data_out, ed);
    check({name, " carry"}, carry_out, ec);
    check({name, " zero"}, zero_out, ed == 0);
    check({name, " neg"}, neg_out, ed[7]);
    check({name, " in_ready"}, in_ready, 0);
    repeat (hold) @(negedge clk);
    if (hold > 0) check({name, " held"}, data_out, ed);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " idle"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] rd;
    logic       rc;

    vecs.push_back('{4'b0001, 8'h81, 1,  8'h02, 1'b1});
    vecs.push_back('{4'b0011, 8'h01, 9,  8'h80, 1'b1});
    vecs.push_back('{4'b0101, 8'h80, 3,  8'hF0, 1'b0});
    vecs.push_back('{4'b0101, 8'h80, 15, 8'hFF, 1'b1});
    vecs.push_back('{4'b0010, 8'hFF, 15, 8'h00, 1'b0});
    vecs.push_back('{4'b0000, 8'h5A, 4,  8'h5A, 1'b0});
    vecs.push_back('{4'b0001, 8'h5A, 0,  8'h5A, 1'b0});
    vecs.push_back('{4'b0100, 8'h0F, 4,  8'hF0, 1'b0});
    vecs.push_back('{4'b0001, 8'h01, 8,  8'h00, 1'b1});
    vecs.push_back('{4'b0010, 8'h80, 8,  8'h00, 1'b1});
    vecs.push_back('{4'b0110, 8'hA5, 3,  8'hA5, 1'b0});
    vecs.push_back('{4'b0100, 8'h81, 5,  8'h30, 1'b0});

    repeat (2) @(negedge clk);
    check("reset outputs", {in_ready, out_valid, busy, carry_out, zero_out, neg_out}, 6'b100000);
    check("reset data", data_out, 8'h00);
    rst_n = 1'b1;

    foreach (vecs[i])
      transact($sformatf("vec%0d", i), vecs[i].op, vecs[i].d, vecs[i].n,
               vecs[i].exp_d, vecs[i].exp_c, 0);

    // DONE held with out_ready low; in_valid while busy is ignored.
    @(negedge clk);
    in_valid = 1'b1; shift_op = 4'b0000; data_in = 8'h5A; shamt = 4'd0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold valid", {out_valid, in_ready, busy}, 3'b101);
      check("hold data", {data_out, carry_out}, {8'h5A, 1'b0});
      in_valid = (i == 2); shift_op = 4'b0001; data_in = 8'hFF; shamt = 4'd3;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("hold data after pulse", data_out, 8'h5A);
    // Request presented on the release cycle must wait one cycle.
    in_valid = 1'b1; shift_op = 4'b0000; data_in = 8'h33; shamt = 4'd0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release idle", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    check("accept after release", {out_valid, data_out}, {1'b1, 8'h33});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    in_valid = 1'b1; shift_op = 4'b0100; data_in = 8'h0F; shamt = 4'd7;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid-shift busy", {busy, out_valid}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("abort outputs", {in_ready, out_valid, busy, carry_out, zero_out, neg_out}, 6'b100000);
    check("abort data", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    transact("post-reset lsl", 4'b0001, 8'h01, 2, 8'h04, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic [7:0] d;
      int n;
      op = 4'($urandom_range(0, 7));
      d  = 8'($urandom);
      n  = $urandom_range(0, 15);
      model(op, d, n, rd, rc);
      transact($sformatf("rand%0d op%0d d%02h n%0d", i, op, d, n), op, d, n, rd, rc,
               $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
